// File: rtl/bcd_counter_mux.sv
// Multi-digit BCD up/down counter with a programmable prescaler and a scanned
// seven-segment driver. The display scan runs on clk whether or not counting is enabled.
module bcd_counter_mux #(
  parameter int                    DIGITS     = 4,
  parameter int                    PRESCALE_W = 24,
  parameter logic [PRESCALE_W-1:0] MAX_COUNT  = 24'd9_999_999,
  parameter int                    SCAN_W     = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [7:0]            compare_in,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  tick,
  output logic                  wrap,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);

  logic [PRESCALE_W-1:0]  prescaler;
  logic [PRESCALE_W-1:0]  compare;
  logic [17:0]            compare_scaled;
  logic [DIGITS-1:0][3:0] digits;
  logic [DIGITS-1:0][3:0] digits_step;
  logic [DIGITS-1:0][3:0] digits_load;
  logic                   chain;
  logic                   step_wrap;
  logic [DIGITS-1:0]      lz;
  logic                   lz_run;
  logic [SCAN_W-1:0]      scan_cnt;
  logic [IDX_W-1:0]       scan_idx;
  logic [3:0]             cur_digit;
  logic                   cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign count_bcd      = digits;
  assign compare_scaled = {compare_in, 10'b0};

  always_comb begin
    compare = (compare_in == 8'd0) ? MAX_COUNT : PRESCALE_W'(compare_scaled);
  end

  // Ripple carry/borrow: chain stays high while every lower digit rolled over,
  // so a chain still high past the top digit means the full range wrapped.
  always_comb begin
    chain       = 1'b1;
    digits_step = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (chain) begin
        if (up_down) begin
          if (digits[k] >= 4'd9) begin
            digits_step[k] = 4'd0;
          end else begin
            digits_step[k] = digits[k] + 4'd1;
            chain          = 1'b0;
          end
        end else begin
          if (digits[k] == 4'd0) begin
            digits_step[k] = 4'd9;
          end else begin
            digits_step[k] = digits[k] - 4'd1;
            chain          = 1'b0;
          end
        end
      end
    end
    step_wrap = chain;
  end

  always_comb begin
    digits_load = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digits_load[k] = (load_value[4*k +: 4] > 4'd9) ? 4'd0 : load_value[4*k +: 4];
    end
  end

  // lz[k] is set when digit k and every digit above it are zero.
  always_comb begin
    lz_run = 1'b1;
    lz     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run && (digits[k] == 4'd0);
      lz[k]  = lz_run;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      digits    <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (clear) begin
      prescaler <= '0;
      digits    <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      prescaler <= '0;
      digits    <= digits_load;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (enable) begin
      // >= rather than == so lowering compare_in mid-count terminates at once.
      if (prescaler >= compare) begin
        prescaler <= '0;
        digits    <= digits_step;
        tick      <= 1'b1;
        wrap      <= step_wrap;
      end else begin
        prescaler <= prescaler + PRESCALE_W'(1);
        tick      <= 1'b0;
        wrap      <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  assign cur_digit = digits[scan_idx];
  assign cur_blank = blank_lz && (scan_idx != '0) && lz[scan_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      digit_sel <= SEL_ONE;
      segments  <= 7'h3F;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
      if (&scan_cnt) begin
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
      end
      // Select and pattern come from the same index so they never disagree.
      digit_sel <= SEL_ONE << scan_idx;
      segments  <= cur_blank ? 7'h00 : seg_decode(cur_digit);
    end
  end

endmodule

// File: tb/tb_bcd_counter_mux.sv
// Directed bench for bcd_counter_mux: prescaler period, BCD carry/borrow and wrap,
// load/clear priority, compare change mid-count, and the scanned display with blanking.
module tb_bcd_counter_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        up_down = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic [7:0]  compare_in = 8'd1;
  logic        blank_lz = 1'b0;
  logic [15:0] count_bcd;
  logic        tick;
  logic        wrap;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_counter_mux #(
    .DIGITS(4), .PRESCALE_W(24), .MAX_COUNT(24'd9_999_999), .SCAN_W(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .compare_in(compare_in), .blank_lz(blank_lz),
    .count_bcd(count_bcd), .tick(tick), .wrap(wrap), .segments(segments),
    .digit_sel(digit_sel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 3000);
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout: no tick within %0d cycles", n);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load_value = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset(input string tag);
    reset = 1'b1;
    step();
    step();
    checks++;
    if (count_bcd !== 16'h0000 || tick !== 1'b0 || wrap !== 1'b0 ||
        digit_sel !== 4'b0001 || segments !== 7'h3F) begin
      errors++;
      $display("FAIL %s: count=%h tick=%b wrap=%b sel=%b seg=%h, want 0000 0 0 0001 3f",
               tag, count_bcd, tick, wrap, digit_sel, segments);
    end
    reset = 1'b0;
  endtask

  task automatic test_count();
    int n;
    logic [15:0] exp;
    for (int i = 1; i <= 10; i++) begin
      wait_tick(n);
      exp = (i == 10) ? 16'h0010 : 16'(i);
      checks++;
      if (n !== 1025 || count_bcd !== exp || wrap !== 1'b0) begin
        errors++;
        $display("FAIL count_tick%0d: period=%0d count=%h wrap=%b, want 1025 %h 0",
                 i, n, count_bcd, wrap, exp);
      end
    end
    step();
    checks++;
    if (tick !== 1'b0 || count_bcd !== 16'h0010) begin
      errors++;
      $display("FAIL tick_width: tick=%b count=%h, want 0 0010", tick, count_bcd);
    end
  endtask

  task automatic test_wrap_up();
    int n;
    up_down = 1'b1;
    pulse_load(16'h9998);
    checks++;
    if (count_bcd !== 16'h9998 || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_9998: count=%h tick=%b, want 9998 0", count_bcd, tick);
    end
    wait_tick(n);
    checks++;
    if (count_bcd !== 16'h9999 || wrap !== 1'b0 || n !== 1025) begin
      errors++;
      $display("FAIL up_9999: count=%h wrap=%b period=%0d, want 9999 0 1025", count_bcd, wrap, n);
    end
    wait_tick(n);
    checks++;
    if (count_bcd !== 16'h0000 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap: count=%h wrap=%b, want 0000 1", count_bcd, wrap);
    end
    step();
    checks++;
    if (wrap !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL wrap_width: wrap=%b tick=%b, want 0 0", wrap, tick);
    end
  endtask

  task automatic test_wrap_down();
    int n;
    up_down = 1'b0;
    pulse_load(16'h0000);
    wait_tick(n);
    checks++;
    if (count_bcd !== 16'h9999 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: count=%h wrap=%b, want 9999 1", count_bcd, wrap);
    end
    wait_tick(n);
    checks++;
    if (count_bcd !== 16'h9998 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_9998: count=%h wrap=%b, want 9998 0", count_bcd, wrap);
    end
    pulse_load(16'h3100);
    wait_tick(n);
    checks++;
    if (count_bcd !== 16'h3099) begin
      errors++;
      $display("FAIL down_borrow: count=%h, want 3099", count_bcd);
    end
    up_down = 1'b1;
  endtask

  task automatic test_load_clear();
    pulse_load(16'h12AF);
    checks++;
    if (count_bcd !== 16'h1200) begin
      errors++;
      $display("FAIL load_invalid: count=%h, want 1200", count_bcd);
    end
    load_value = 16'h1234;
    load = 1'b1;
    clear = 1'b1;
    step();
    load = 1'b0;
    clear = 1'b0;
    checks++;
    if (count_bcd !== 16'h0000 || tick !== 1'b0) begin
      errors++;
      $display("FAIL clear_over_load: count=%h tick=%b, want 0000 0", count_bcd, tick);
    end
  endtask

  task automatic test_enable_hold();
    int ticks_seen = 0;
    pulse_load(16'h0005);
    enable = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (tick === 1'b1) ticks_seen++;
      if (i == 700) up_down = 1'b0;
    end
    checks++;
    if (ticks_seen != 0 || count_bcd !== 16'h0005) begin
      errors++;
      $display("FAIL enable_hold: ticks=%0d count=%h, want 0 0005", ticks_seen, count_bcd);
    end
    up_down = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_compare_switch();
    int n;
    int ticks_seen = 0;
    compare_in = 8'd0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (tick === 1'b1) ticks_seen++;
    end
    checks++;
    if (ticks_seen != 0 || count_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL max_count_quiet: ticks=%0d count=%h, want 0 0000", ticks_seen, count_bcd);
    end
    compare_in = 8'd1;
    step();
    checks++;
    if (tick !== 1'b1 || count_bcd !== 16'h0001) begin
      errors++;
      $display("FAIL compare_lowered: tick=%b count=%h, want 1 0001", tick, count_bcd);
    end
    wait_tick(n);
    checks++;
    if (n !== 1025 || count_bcd !== 16'h0002) begin
      errors++;
      $display("FAIL compare_period: period=%0d count=%h, want 1025 0002", n, count_bcd);
    end
  endtask

  task automatic sync_scan();
    int n = 0;
    while (digit_sel === 4'b0001 && n < 40) begin step(); n++; end
    while (digit_sel !== 4'b0001 && n < 40) begin step(); n++; end
    checks++;
    if (digit_sel !== 4'b0001) begin
      errors++;
      $display("FAIL scan_sync: sel=%b after %0d cycles, want 0001", digit_sel, n);
    end
  endtask

  task automatic test_scan(input logic blank);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_sel;
    if (blank) exp_seg = '{7'h5B, 7'h66, 7'h00, 7'h00};
    else       exp_seg = '{7'h5B, 7'h66, 7'h3F, 7'h3F};
    blank_lz = blank;
    sync_scan();
    for (int i = 0; i < 4; i++) begin
      exp_sel = 4'b0001 << i;
      checks++;
      if (digit_sel !== exp_sel || segments !== exp_seg[i]) begin
        errors++;
        $display("FAIL scan_blank%0b_pos%0d: sel=%b seg=%h, want %b %h",
                 blank, i, digit_sel, segments, exp_sel, exp_seg[i]);
      end
      repeat (4) step();
    end
  endtask

  initial begin
    test_reset("reset_init");
    test_count();
    test_wrap_up();
    test_wrap_down();
    test_load_clear();
    test_enable_hold();
    test_compare_switch();
    pulse_load(16'h0042);
    enable = 1'b0;
    test_scan(1'b1);
    test_scan(1'b0);
    enable = 1'b1;
    test_reset("reset_midrun");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
